// File: rtl/max7219_pkg.sv
// Shared constants, state types and init-word table for the MAX7219 display driver.
package max7219_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCAN      = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam int FRAME_BITS = 16;
  localparam int INIT_WORDS = 5;

  typedef enum logic [2:0] {
    ST_INIT_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_IDLE,
    ST_REFR_LOAD
  } state_e;

  typedef enum logic {
    SEQ_INIT,
    SEQ_REFR
  } seq_e;

  // Power-up register writes, issued in index order 0..INIT_WORDS-1.
  function automatic logic [15:0] init_word(input logic [2:0] k,
                                            input logic [3:0] scan,
                                            input logic [3:0] inten);
    logic [15:0] w;
    case (k)
      3'd0:    w = {4'h0, REG_SHUTDOWN, 8'h01};
      3'd1:    w = {4'h0, REG_TEST, 8'h00};
      3'd2:    w = {4'h0, REG_SCAN, 4'h0, scan};
      3'd3:    w = {4'h0, REG_DECODE, 8'hFF};
      default: w = {4'h0, REG_INTENSITY, 4'h0, inten};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/max7219_display_driver_spi_frame_tx.sv
// Shifts one 16-bit frame out MSB first with CS framing, then holds an inter-frame gap.
module spi_frame_tx
  import max7219_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] word,
  output logic        done,
  output logic        gap,
  output logic        mosi,
  output logic        cs,
  output logic        sclk
);

  localparam int              DW        = $clog2(2 * CLK_DIV) + 1;
  localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
  // The load cycle in the sequencer supplies the final gap cycle.
  localparam logic [DW-1:0]   GAP_LAST  = DW'(2 * CLK_DIV - 2);
  localparam logic [4:0]      HALF_LAST = 5'(2 * FRAME_BITS - 1);

  logic [15:0]   sr_q, sr_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    half_q, half_d;
  logic          active_q, active_d;
  logic          gap_q, gap_d;
  logic          mosi_q, mosi_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    sr_d     = sr_q;
    div_d    = div_q;
    half_d   = half_q;
    active_d = active_q;
    gap_d    = gap_q;
    mosi_d   = mosi_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    done     = active_q && gap_q && (div_q == GAP_LAST);

    if (start) begin
      sr_d     = word;
      div_d    = '0;
      half_d   = '0;
      active_d = 1'b1;
      gap_d    = 1'b0;
      cs_d     = 1'b0;
      sclk_d   = 1'b0;
      mosi_d   = word[15];
    end else if (active_q && !gap_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (!half_q[0]) begin
          sclk_d = 1'b1;
          half_d = half_q + 5'd1;
        end else if (half_q == HALF_LAST) begin
          gap_d  = 1'b1;
          cs_d   = 1'b1;
          sclk_d = 1'b0;
          mosi_d = 1'b0;
        end else begin
          // Falling edge: the only moment MOSI is allowed to move.
          sclk_d = 1'b0;
          sr_d   = {sr_q[14:0], 1'b0};
          mosi_d = sr_q[14];
          half_d = half_q + 5'd1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end else if (active_q) begin
      if (done) begin
        active_d = 1'b0;
        gap_d    = 1'b0;
        div_d    = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      div_q    <= '0;
      half_q   <= '0;
      active_q <= 1'b0;
      gap_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      div_q    <= div_d;
      half_q   <= half_d;
      active_q <= active_d;
      gap_q    <= gap_d;
      mosi_q   <= mosi_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
    end
  end

  assign gap  = gap_q;
  assign mosi = mosi_q;
  assign cs   = cs_q;
  assign sclk = sclk_q;

endmodule

// File: rtl/max7219_display_driver.sv
// MAX7219 sequencer: power-up/on-demand init, then tear-free continuous refresh while enabled.
module max7219_display_driver
  import max7219_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_DIV    = 4,
  parameter int INTENSITY  = 8
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    ena,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    reinit,
  output logic                    busy,
  output logic                    MOSI,
  output logic                    CS,
  output logic                    clk_SPI
);

  localparam logic [3:0] SCAN4      = 4'(NUM_DIGITS - 1);
  localparam logic [3:0] INTEN4     = 4'(INTENSITY);
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [2:0] LAST_INIT  = 3'(INIT_WORDS - 1);

  state_e                  state_q, state_d;
  seq_e                    seq_q, seq_d;
  logic [2:0]              idx_q, idx_d;
  logic                    pend_q, pend_d;
  logic                    busy_q, busy_d;
  logic [4*NUM_DIGITS-1:0] dig_s_q, dig_s_d;
  logic [NUM_DIGITS-1:0]   dp_s_q, dp_s_d;

  logic        tx_start, tx_done, tx_gap;
  logic [15:0] tx_word;
  logic [31:0] dig_pad;
  logic [7:0]  dp_pad;

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    idx_d    = idx_q;
    pend_d   = pend_q | reinit;
    dig_s_d  = dig_s_q;
    dp_s_d   = dp_s_q;
    tx_start = 1'b0;
    tx_word  = 16'h0000;
    dig_pad  = '0;
    dp_pad   = '0;

    case (state_q)
      ST_INIT_LOAD: begin
        tx_start = 1'b1;
        tx_word  = init_word(idx_q, SCAN4, INTEN4);
        seq_d    = SEQ_INIT;
        pend_d   = reinit;
        state_d  = ST_SHIFT;
      end
      ST_REFR_LOAD: begin
        // Digit 0 latches the whole frame so a refresh never mixes old and new values.
        if (idx_q == 3'd0) begin
          dig_s_d = digits;
          dp_s_d  = dp;
        end
        dig_pad[4*NUM_DIGITS-1:0] = dig_s_d;
        dp_pad[NUM_DIGITS-1:0]    = dp_s_d;
        tx_start = 1'b1;
        tx_word  = {4'h0, REG_DIGIT0 + {1'b0, idx_q}, dp_pad[idx_q], 3'b000,
                    dig_pad[{idx_q, 2'b00} +: 4]};
        seq_d    = SEQ_REFR;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT, ST_GAP: begin
        if (tx_done) begin
          if (seq_q == SEQ_INIT) begin
            if (idx_q == LAST_INIT) begin
              state_d = ST_IDLE;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = ST_INIT_LOAD;
            end
          end else begin
            if (idx_q == LAST_DIGIT) begin
              state_d = ST_IDLE;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = ST_REFR_LOAD;
            end
          end
        end else if (tx_gap) begin
          state_d = ST_GAP;
        end
      end
      ST_IDLE: begin
        if (pend_q || reinit) begin
          idx_d   = 3'd0;
          state_d = ST_INIT_LOAD;
        end else if (ena) begin
          idx_d   = 3'd0;
          state_d = ST_REFR_LOAD;
        end
      end
      default: state_d = ST_INIT_LOAD;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_INIT_LOAD;
      seq_q   <= SEQ_INIT;
      idx_q   <= 3'd0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b1;
      dig_s_q <= '0;
      dp_s_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      dig_s_q <= dig_s_d;
      dp_s_q  <= dp_s_d;
    end
  end

  assign busy = busy_q;

  spi_frame_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .rst_n (res),
    .start (tx_start),
    .word  (tx_word),
    .done  (tx_done),
    .gap   (tx_gap),
    .mosi  (MOSI),
    .cs    (CS),
    .sclk  (clk_SPI)
  );

endmodule

// File: tb/tb_max7219_display_driver.sv
// Decodes the SPI pins back into words and checks them against a frame-level display model.
module tb_max7219_display_driver;

  localparam int NUM_DIGITS = 6;
  localparam int CLK_DIV    = 2;
  localparam int INTENSITY  = 8;

  logic                    clk;
  logic                    res;
  logic                    ena;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    reinit;
  logic                    busy;
  logic                    MOSI;
  logic                    CS;
  logic                    clk_SPI;

  max7219_display_driver #(
    .NUM_DIGITS(NUM_DIGITS),
    .CLK_DIV   (CLK_DIV),
    .INTENSITY (INTENSITY)
  ) dut (
    .clk     (clk),
    .res     (res),
    .ena     (ena),
    .digits  (digits),
    .dp      (dp),
    .reinit  (reinit),
    .busy    (busy),
    .MOSI    (MOSI),
    .CS      (CS),
    .clk_SPI (clk_SPI)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] init_lit [5] = '{16'h0C01, 16'h0F00, 16'h0B05, 16'h09FF, 16'h0A08};
  logic [15:0] refr_lit [6] = '{16'h0106, 16'h0205, 16'h0384, 16'h0403, 16'h0502, 16'h0601};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode 0 = init words, mode 1 = digit refresh; idx is the position in that sequence.
  function automatic logic [15:0] model_word(input int mode, input int idx,
                                             input logic [23:0] d, input logic [5:0] p);
    int w;
    if (mode == 0) begin
      case (idx)
        0:       w = 'h0C01;
        1:       w = 'h0F00;
        2:       w = 'h0B00 + NUM_DIGITS - 1;
        3:       w = 'h09FF;
        default: w = 'h0A00 + INTENSITY;
      endcase
    end else begin
      w = ((idx + 1) << 8) + (int'(p[idx]) << 7) + (int'(d >> (4 * idx)) & 'hF);
    end
    return 16'(w);
  endfunction

  int reinit_req = 0;
  int reinit_seen = 0;

  int          m_mode, m_idx;
  bit          m_seq_end, m_first;
  logic [23:0] m_dig;
  logic [5:0]  m_dp;

  logic [15:0] exp_q[$];
  logic [15:0] log_q[$];

  int          cyc = 0;
  int          last_fall = 0;
  int          nframes = 0;
  bit          in_frame = 0;
  int          nb = 0;
  int          low_cnt = 0;
  logic [15:0] sh = '0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (!res) begin
      in_frame    = 0;
      prev_cs     = 1'b1;
      prev_sclk   = 1'b0;
      m_mode      = 0;
      m_idx       = -1;
      m_seq_end   = 0;
      m_first     = 1;
      reinit_seen = reinit_req;
      exp_q.delete();
    end else begin
      check("sclk_quiet_while_cs_high", {31'd0, CS & clk_SPI}, 32'd0);
      if (!CS) check("busy_during_frame", {31'd0, busy}, 32'd1);
      if (in_frame && prev_sclk && clk_SPI) check("mosi_stable_sclk_high", {31'd0, MOSI}, {31'd0, prev_mosi});

      if (prev_cs && !CS) begin
        in_frame = 1;
        nb       = 0;
        low_cnt  = 0;
        sh       = '0;
        if (m_seq_end) begin
          if (reinit_req != reinit_seen) begin
            m_mode      = 0;
            m_idx       = 0;
            reinit_seen = reinit_req;
          end else if (ena) begin
            m_mode = 1;
            m_idx  = 0;
            m_dig  = digits;
            m_dp   = dp;
          end else begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: frame started while display should stay idle (t=%0t)", $time);
            m_mode = 1;
            m_idx  = 0;
          end
        end else begin
          m_idx++;
          if (!m_first) check("frame_period", cyc - last_fall, 34 * CLK_DIV);
        end
        m_first   = 0;
        last_fall = cyc;
        exp_q.push_back(model_word(m_mode, m_idx, m_dig, m_dp));
        m_seq_end = (m_mode == 0 && m_idx == 4) || (m_mode == 1 && m_idx == NUM_DIGITS - 1);
      end

      if (!CS) low_cnt++;
      if (in_frame && !prev_sclk && clk_SPI) begin
        sh = {sh[14:0], MOSI};
        nb++;
      end

      if (in_frame && CS) begin
        in_frame = 0;
        nframes++;
        check("frame_bits", nb, 16);
        check("cs_low_cycles", low_cnt, 32 * CLK_DIV);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL frame_word: got 0x%0h, expected no frame", sh);
        end else begin
          check("frame_word", {16'd0, sh}, {16'd0, exp_q.pop_front()});
        end
        log_q.push_back(sh);
      end

      prev_cs   = CS;
      prev_sclk = clk_SPI;
      prev_mosi = MOSI;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frames(input int n);
    int tgt;
    int b;
    tgt = nframes + n;
    b = 0;
    while (nframes < tgt && b < 20000) begin
      @(negedge clk); #1;
      b++;
    end
    if (nframes < tgt) check("wait_frames_timeout", nframes, tgt);
  endtask

  task automatic wait_word_end(input int idx);
    int k;
    k = 0;
    do begin
      wait_frames(1);
      k++;
    end while (!(m_mode == 1 && m_idx == idx) && k < 20);
    check("reached_refresh_word", m_idx, idx);
  endtask

  task automatic wait_idle(input int limit);
    int b;
    b = 0;
    while (busy !== 1'b0 && b < limit) begin
      @(negedge clk); #1;
      b++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    reinit_req++;
    @(negedge clk); #1;
    reinit = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    int base;
    int b;
    res    = 1'b1;
    ena    = 1'b0;
    digits = 24'h123456;
    dp     = 6'b000100;
    reinit = 1'b0;
    #2 res = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_cs", {31'd0, CS}, 32'd1);
    check("reset_sclk", {31'd0, clk_SPI}, 32'd0);
    check("reset_mosi", {31'd0, MOSI}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd1);
    res = 1'b1;

    // power-up init
    wait_idle(3000);
    check("init_frame_count", nframes, 5);
    for (int i = 0; i < 5; i++) check("init_word_literal", {16'd0, log_q[i]}, {16'd0, init_lit[i]});

    // continuous refresh
    ena = 1'b1;
    wait_frames(6);
    for (int i = 0; i < 6; i++) check("refresh_word_literal", {16'd0, log_q[5 + i]}, {16'd0, refr_lit[i]});
    wait_frames(6);

    // inputs change mid-refresh: remainder keeps old values, next refresh takes new ones
    for (int r = 0; r < 4; r++) begin
      wait_word_end(1);
      base   = log_q.size();
      digits = 24'($urandom);
      dp     = 6'($urandom_range(0, 63));
      wait_frames(4 + NUM_DIGITS);
      if (r == 0) check("no_tearing_literal", {16'd0, log_q[base]}, 32'h0384);
    end

    // drop ena after the second word
    wait_word_end(1);
    ena = 1'b0;
    n0  = nframes;
    wait_idle(2000);
    check("frames_after_ena_drop", nframes - n0, 4);
    repeat (200) @(negedge clk);
    #1;
    check("idle_cs", {31'd0, CS}, 32'd1);
    check("idle_sclk", {31'd0, clk_SPI}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_no_frames", nframes - n0, 4);

    // reinit during a refresh
    ena = 1'b1;
    wait_word_end(2);
    base = log_q.size();
    pulse_reinit();
    wait_frames(3 + 5 + NUM_DIGITS);
    check("reinit_first_literal", {16'd0, log_q[base + 3]}, 32'h0C01);
    check("reinit_last_literal", {16'd0, log_q[base + 7]}, 32'h0A08);

    // asynchronous reset during bit 7
    b = 0;
    while (!(in_frame && nb == 8 && !clk_SPI) && b < 2000) begin
      @(negedge clk); #1;
      b++;
    end
    check("reached_bit7", nb, 8);
    #2 res = 1'b0;
    #1;
    check("midframe_reset_cs", {31'd0, CS}, 32'd1);
    check("midframe_reset_sclk", {31'd0, clk_SPI}, 32'd0);
    check("midframe_reset_mosi", {31'd0, MOSI}, 32'd0);
    check("midframe_reset_busy", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    #1 res = 1'b1;
    wait_frames(1);
    check("first_after_reset", {16'd0, log_q[log_q.size() - 1]}, 32'h0C01);

    // more random refreshes, then idle reinit
    wait_frames(4 + NUM_DIGITS);
    for (int r = 0; r < 2; r++) begin
      wait_word_end($urandom_range(0, NUM_DIGITS - 3));
      digits = 24'($urandom);
      dp     = 6'($urandom);
      wait_frames(NUM_DIGITS);
    end
    wait_word_end(1);
    ena = 1'b0;
    wait_idle(2000);
    n0 = nframes;
    pulse_reinit();
    wait_idle(2000);
    check("idle_reinit_frames", nframes - n0, 5);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
